tl_dma_arbiter: RTL and testbench
=================================

Name: tl_dma_arbiter

Overview:
- Shares the single TileLink DMA host port of the cache-coherence complex between NumHosts IO DMA masters.
- Round-robin arbitrates channel A and keeps multi-beat writes atomic.
- Tags each request's source with the requester index and routes channel D responses back by that tag.
- Only channels A and D are used: uncached TL-UH traffic. B, C and E are tied off by the integrator.

Parameters:
- NumHosts, 2: number of DMA requesters (≥2).
- DataWidth, 128: bus width in bits, identical on all ports.
- AddrWidth, 38: address width.
- HostSourceWidth, 2: source width of each requester.
- SourceWidth, HostSourceWidth+$clog2(NumHosts): device-side source width. Must equal the CCX DmaSourceWidth (3).
- MaxSize, 6: largest log2 transfer size. Requests above this are a protocol error; assert in simulation.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- host_a_valid_i  in  NumHosts  per-requester A valid
- host_a_ready_o  out  NumHosts  per-requester A ready
- host_a_i  in  NumHosts×A_W  A-channel bundles. A_W = opcode3+param3+size3+source(HostSourceWidth)+address+mask(DataWidth/8)+corrupt1+data.
- host_d_valid_o  out  NumHosts  per-requester D valid
- host_d_ready_i  in  NumHosts  per-requester D ready
- host_d_o  out  D_W  D bundle, broadcast to all requesters. D_W = opcode3+param2+size3+source(HostSourceWidth)+sink1+denied1+corrupt1+data.
- dev_a_valid_o / dev_a_ready_i / dev_a_o  out/in/out  1/1/A_W'  A channel to the DMA port. A_W' uses SourceWidth.
- dev_d_valid_i / dev_d_ready_o / dev_d_i  in/out/in  1/1/D_W'  D channel from the DMA port.

Behaviour:
- Reset: lock cleared, beat counter 0, rr pointer 0.
  - Outputs combinational from state. With all inputs idle: dev_a_valid_o=0, all host_a_ready_o=0, all host_d_valid_o=0, dev_d_ready_o=0.
- Channel A states:
  - IDLE: grant = first valid requester at or after the rr pointer, wrapping modulo NumHosts.
    - dev_a_valid_o = host_a_valid_i[grant].
    - dev_a_o = host_a_i[grant] with source = {grant, host source}.
    - host_a_ready_o[grant] = dev_a_ready_i; all other readies 0.
    - Zero-cycle arbitration latency. No output register.
  - Beat count: beats = 2^(size-log2(DataWidth/8)) when size > log2(DataWidth/8) and opcode carries data (PutFull 0, PutPartial 1, Arithmetic 2, Logical 3); otherwise 1.
  - On the first-beat handshake with beats>1: go to LOCKED, latch grant, counter = beats-1.
  - LOCKED: grant held. Counter decrements per handshake. At the 0 transition return to IDLE.
  - Single-beat handshake: stay IDLE.
  - rr pointer advances to grant+1 (mod NumHosts) on the last-beat handshake only.
  - If the granted host deasserts valid in IDLE before the handshake, it may be re-arbitrated; TL forbids this, and simulation asserts it.
  - Counter width: $clog2(2^MaxSize·8/DataWidth)+1.
- Channel D: purely combinational, no state.
  - idx = dev_d_i.source[SourceWidth-1 -: $clog2(NumHosts)].
  - host_d_valid_o[idx] = dev_d_valid_i; others 0.
  - dev_d_ready_o = host_d_ready_i[idx].
  - host_d_o = dev_d_i with the index bits stripped.
  - Multi-beat AccessAckData needs no locking: single device, in-order beats per source.
- A and D are independent. Simultaneous A grant and D response to the same requester is legal.
- idx ≥ NumHosts (non-power-of-2 NumHosts): dev_d_ready_o=1, response dropped, simulation assertion fires.
- Reset mid-burst: lock and counter clear immediately (async). Requesters are reset by the same rst_ni.

Decomposition:
- Package tl_dma_arb_pkg: TileLink opcode constants and a function beats(opcode,size,DataWidth).
- One sub-module, rr_arbiter (NumReq): request vector, update strobe, one-hot and index grant, rotating priority pointer. Reusable for other sockets.

Test Plan:
- Single request:
  - Host1 Get, size 4, source 2, address 'h8000_0000.
  - Expect dev_a_o.source 3'b110 in the same cycle.
  - D AccessAckData source 6 → only host_d_valid_o[1], source 2.
- Fairness:
  - Both hosts hold continuous 1-beat Gets.
  - Expect grants alternate 0,1,0,1 over 8 handshakes; no host starves.
- Burst lock:
  - Host0 PutFullData size 6 (4 beats) while host1 requests from beat 1.
  - Expect 4 consecutive host0 beats, then host1.
  - Also with dev_a_ready_i toggling every other cycle: same ordering.
- Backpressure on D:
  - host_d_ready_i[0]=0 for 5 cycles with a response pending for host0.
  - Expect dev_d_ready_o=0 and data stable; consumed on the cycle ready rises.
- Reset mid-burst:
  - Assert rst_ni low after beat 2 of a 4-beat Put.
  - Expect rr pointer 0 and IDLE on release; the next request is arbitrated fresh.
- Concurrent A/D:
  - Host1 A handshake in the same cycle as a D beat to host1.
  - Expect both complete with no dropped beat.

Source files
------------

// File: rtl/tl_dma_arb_pkg.sv
// rtl/tl_dma_arb_pkg.sv - TileLink opcodes, bundle widths and burst beat count for the DMA arbiter
package tl_dma_arb_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITHMETIC  = 3'd2;
    localparam logic [2:0] A_LOGICAL     = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_INTENT      = 3'd5;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    // A: opcode3 param3 size3 source address mask corrupt1 data
    function automatic int a_width(int src_w, int addr_w, int data_w);
        return 9 + src_w + addr_w + data_w / 8 + 1 + data_w;
    endfunction

    // D: opcode3 param2 size3 source sink1 denied1 corrupt1 data
    function automatic int d_width(int src_w, int data_w);
        return 8 + src_w + 3 + data_w;
    endfunction

    function automatic int beats(logic [2:0] opcode, logic [2:0] size, int data_w);
        int lg;
        lg = $clog2(data_w / 8);
        if (opcode <= A_LOGICAL && int'(size) > lg) begin
            return 1 << (int'(size) - lg);
        end
        return 1;
    endfunction

endpackage

// File: rtl/tl_dma_arbiter_if.sv
// rtl/tl_dma_arbiter_if.sv - requester-side and device-side TileLink A/D links of the DMA arbiter
interface tl_dma_arbiter_if #(
    parameter int NumHosts        = 2,
    parameter int DataWidth       = 128,
    parameter int AddrWidth       = 38,
    parameter int HostSourceWidth = 2,
    parameter int SourceWidth     = HostSourceWidth + $clog2(NumHosts)
);
    import tl_dma_arb_pkg::*;

    localparam int HostAW = a_width(HostSourceWidth, AddrWidth, DataWidth);
    localparam int DevAW  = a_width(SourceWidth, AddrWidth, DataWidth);
    localparam int HostDW = d_width(HostSourceWidth, DataWidth);
    localparam int DevDW  = d_width(SourceWidth, DataWidth);

    logic [NumHosts-1:0]             host_a_valid_i;
    logic [NumHosts-1:0]             host_a_ready_o;
    logic [NumHosts-1:0][HostAW-1:0] host_a_i;
    logic [NumHosts-1:0]             host_d_valid_o;
    logic [NumHosts-1:0]             host_d_ready_i;
    logic [HostDW-1:0]               host_d_o;
    logic                            dev_a_valid_o;
    logic                            dev_a_ready_i;
    logic [DevAW-1:0]                dev_a_o;
    logic                            dev_d_valid_i;
    logic                            dev_d_ready_o;
    logic [DevDW-1:0]                dev_d_i;

    modport slave (
        input  host_a_valid_i, host_a_i, host_d_ready_i, dev_a_ready_i, dev_d_valid_i, dev_d_i,
        output host_a_ready_o, host_d_valid_o, host_d_o, dev_a_valid_o, dev_a_o, dev_d_ready_o
    );

    modport master (
        output host_a_valid_i, host_a_i, host_d_ready_i, dev_a_ready_i, dev_d_valid_i, dev_d_i,
        input  host_a_ready_o, host_d_valid_o, host_d_o, dev_a_valid_o, dev_a_o, dev_d_ready_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer advanced on an update strobe
module rr_arbiter #(
    parameter int NumReq = 2,
    localparam int IdxW  = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              update_i,
    output logic [NumReq-1:0] gnt_oh_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    int              j;

    // Walk offsets from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        j         = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NumReq) j = j - NumReq;
            if (req_i[IdxW'(j)]) begin
                gnt_oh_o               = '0;
                gnt_oh_o[IdxW'(j)]     = 1'b1;
                gnt_idx_o              = IdxW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tl_dma_arbiter.sv
// rtl/tl_dma_arbiter.sv - shares one TileLink DMA port between NumHosts requesters, burst-atomic on A, source-routed on D
module tl_dma_arbiter
    import tl_dma_arb_pkg::*;
#(
    parameter int NumHosts        = 2,
    parameter int DataWidth       = 128,
    parameter int AddrWidth       = 38,
    parameter int HostSourceWidth = 2,
    parameter int SourceWidth     = HostSourceWidth + $clog2(NumHosts),
    parameter int MaxSize         = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    tl_dma_arbiter_if.slave  bus
);

    localparam int IdxW   = $clog2(NumHosts);
    localparam int CntW   = $clog2((2 ** MaxSize) * 8 / DataWidth) + 1;
    localparam int HostAW = a_width(HostSourceWidth, AddrWidth, DataWidth);
    localparam int DevDW  = d_width(SourceWidth, DataWidth);
    localparam int ASrcLo = DataWidth + 1 + DataWidth / 8 + AddrWidth;
    localparam int DSrcLo = DataWidth + 3;

    logic                lock_q, lock_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [NumHosts-1:0] req, gnt_oh;
    logic [IdxW-1:0]     gnt_idx;
    logic [HostAW-1:0]   a_sel;
    logic                hs, last_beat;
    int                  nbeats;

    // While a burst is in flight only its owner may reach the arbiter, so the grant stays put.
    assign req = lock_q ? (bus.host_a_valid_i & (NumHosts'(1) << lock_idx_q)) : bus.host_a_valid_i;

    rr_arbiter #(.NumReq(NumHosts)) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req),
        .update_i  (last_beat),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    assign a_sel              = bus.host_a_i[gnt_idx];
    assign bus.dev_a_valid_o  = |gnt_oh;
    assign bus.dev_a_o        = {a_sel[HostAW-1:ASrcLo+HostSourceWidth], gnt_idx,
                                 a_sel[ASrcLo+HostSourceWidth-1:0]};
    assign bus.host_a_ready_o = gnt_oh & {NumHosts{bus.dev_a_ready_i}};

    assign hs        = bus.dev_a_valid_o & bus.dev_a_ready_i;
    assign nbeats    = beats(a_sel[HostAW-1 -: 3], a_sel[HostAW-7 -: 3], DataWidth);
    assign last_beat = hs & (lock_q ? (cnt_q == CntW'(1)) : (nbeats == 1));

    always_comb begin
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            if (lock_q) begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) lock_d = 1'b0;
            end else if (nbeats > 1) begin
                lock_d     = 1'b1;
                cnt_d      = CntW'(nbeats - 1);
                lock_idx_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    logic [IdxW-1:0] d_idx;
    logic            d_idx_ok;

    // Unmapped indices can only arise with non-power-of-two NumHosts; they are sunk, never stalled.
    assign d_idx              = bus.dev_d_i[DSrcLo+SourceWidth-1 -: IdxW];
    assign d_idx_ok           = int'(d_idx) < NumHosts;
    assign bus.host_d_valid_o = (bus.dev_d_valid_i && d_idx_ok) ? (NumHosts'(1) << d_idx) : '0;
    assign bus.dev_d_ready_o  = d_idx_ok ? bus.host_d_ready_i[d_idx] : 1'b1;
    assign bus.host_d_o       = {bus.dev_d_i[DevDW-1:DSrcLo+SourceWidth],
                                 bus.dev_d_i[DSrcLo+HostSourceWidth-1:0]};

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.dev_a_valid_o |-> int'(a_sel[HostAW-7 -: 3]) <= MaxSize);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.dev_a_valid_o && !bus.dev_a_ready_i && !lock_q) |=> |($past(gnt_oh) & bus.host_a_valid_i));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.dev_d_valid_i |-> d_idx_ok);

endmodule

// File: tb/tb_tl_dma_arbiter.sv
// tb/tb_tl_dma_arbiter.sv - directed and randomized bench for tl_dma_arbiter against a transaction-level model
module tb_tl_dma_arbiter;

    localparam int NH   = 2;
    localparam int DW   = 128;
    localparam int AW   = 38;
    localparam int HSW  = 2;
    localparam int SW   = 3;
    localparam int HAW  = 9 + HSW + AW + DW / 8 + 1 + DW;
    localparam int DAW  = HAW + 1;
    localparam int HDW  = 8 + HSW + 3 + DW;
    localparam int DDW  = HDW + 1;
    localparam int ASRC = DW + 1 + DW / 8 + AW;

    typedef struct {
        logic [2:0]     op;
        logic [2:0]     size;
        logic [HSW-1:0] src;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_dma_arbiter_if #(.NumHosts(NH), .DataWidth(DW), .AddrWidth(AW), .HostSourceWidth(HSW)) bus ();

    tl_dma_arbiter #(
        .NumHosts(NH), .DataWidth(DW), .AddrWidth(AW), .HostSourceWidth(HSW), .SourceWidth(SW), .MaxSize(6)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   m_ptr, m_owner, m_rem;
    req_t hq [NH][$];
    int   glog[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk_req(logic [2:0] op, logic [2:0] size, logic [HSW-1:0] src,
                                    logic [AW-1:0] addr, logic [DW-1:0] data);
        req_t r;
        r.op = op; r.size = size; r.src = src; r.addr = addr; r.data = data;
        return r;
    endfunction

    function automatic logic [HAW-1:0] host_a(req_t r);
        return {r.op, 3'b000, r.size, r.src, r.addr, {(DW/8){1'b1}}, 1'b0, r.data};
    endfunction

    function automatic logic [DAW-1:0] dev_a(req_t r, int g);
        return {r.op, 3'b000, r.size, 1'(g), r.src, r.addr, {(DW/8){1'b1}}, 1'b0, r.data};
    endfunction

    function automatic logic [DDW-1:0] dev_d(logic [2:0] op, logic [2:0] size, logic [SW-1:0] src, logic [DW-1:0] data);
        return {op, 2'b00, size, src, 3'b000, data};
    endfunction

    function automatic logic [HDW-1:0] host_d(logic [2:0] op, logic [2:0] size, logic [HSW-1:0] src, logic [DW-1:0] data);
        return {op, 2'b00, size, src, 3'b000, data};
    endfunction

    // A 16-byte bus carries 2^(size-4) beats for data-carrying opcodes above 16 bytes.
    function automatic int nbeats(req_t r);
        if (r.op <= 3'd3 && int'(r.size) > 4) return 1 << (int'(r.size) - 4);
        return 1;
    endfunction

    function automatic int exp_grant(logic [NH-1:0] v);
        if (m_rem > 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NH; k++) begin
            if (v[(m_ptr + k) % NH]) return (m_ptr + k) % NH;
        end
        return -1;
    endfunction

    task automatic model_hs(input int g, input req_t r);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_ptr = (g + 1) % NH;
        end else if (nbeats(r) > 1) begin
            m_owner = g;
            m_rem   = nbeats(r) - 1;
        end else begin
            m_ptr = (g + 1) % NH;
        end
    endtask

    task automatic push_req(input int h, input req_t r);
        req_t b;
        for (int k = 0; k < nbeats(r); k++) begin
            b = r;
            b.data = r.data + DW'(k);
            hq[h].push_back(b);
        end
    endtask

    task automatic clear_inputs();
        bus.host_a_valid_i = '0;
        bus.host_a_i       = '0;
        bus.host_d_ready_i = '0;
        bus.dev_a_ready_i  = 1'b0;
        bus.dev_d_valid_i  = 1'b0;
        bus.dev_d_i        = '0;
    endtask

    // mode 0: device always ready, 1: ready every other cycle, 2: random ready plus random D traffic
    task automatic run(input int budget, input int mode, input int stop_after);
        int             cyc;
        int             g;
        int             idx;
        logic [NH-1:0]  v;
        req_t           r;
        logic [2:0]     d_size;
        logic [SW-1:0]  d_src;
        logic [DW-1:0]  d_data;
        cyc = 0;
        d_size = '0; d_src = '0; d_data = '0;
        glog.delete();
        while ((hq[0].size() > 0 || hq[1].size() > 0) && cyc < budget && glog.size() < stop_after) begin
            for (int h = 0; h < NH; h++) begin
                v[h] = hq[h].size() > 0;
                bus.host_a_valid_i[h] = v[h];
                bus.host_a_i[h] = v[h] ? host_a(hq[h][0]) : '0;
            end
            bus.dev_a_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            if (mode == 2) begin
                d_src  = SW'($urandom);
                d_size = 3'($urandom_range(0, 6));
                d_data = {$urandom, $urandom, $urandom, $urandom};
                bus.dev_d_valid_i  = 1'($urandom_range(0, 1));
                bus.dev_d_i        = dev_d(3'd1, d_size, d_src, d_data);
                bus.host_d_ready_i = NH'($urandom);
            end
            @(negedge clk);
            g = exp_grant(v);
            chk("a_valid", 256'(bus.dev_a_valid_o), 256'(g >= 0));
            chk("a_ready", 256'(bus.host_a_ready_o), (g >= 0 && bus.dev_a_ready_i) ? 256'(1) << g : 256'(0));
            if (g >= 0) chk("a_bundle", 256'(bus.dev_a_o), 256'(dev_a(hq[g][0], g)));
            if (mode == 2) begin
                idx = int'(d_src) >> HSW;
                chk("d_valid", 256'(bus.host_d_valid_o), bus.dev_d_valid_i ? 256'(1) << idx : 256'(0));
                chk("d_ready", 256'(bus.dev_d_ready_o), 256'(bus.host_d_ready_i[idx]));
                chk("d_bundle", 256'(bus.host_d_o), 256'(host_d(3'd1, d_size, d_src[HSW-1:0], d_data)));
            end
            if (g >= 0 && bus.dev_a_ready_i) begin
                r = hq[g].pop_front();
                glog.push_back(g);
                model_hs(g, r);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("cycle_budget", 256'(cyc < budget), 256'(1));
        bus.dev_d_valid_i = 1'b0;
    endtask

    // pattern bit k holds the host expected at handshake k
    task automatic chk_order(input string tag, input int n, input logic [15:0] pattern);
        int got;
        chk({tag, "_len"}, 256'(glog.size()), 256'(n));
        for (int k = 0; k < n; k++) begin
            got = (k < glog.size()) ? glog[k] : -1;
            chk($sformatf("%s_%0d", tag, k), 256'(got), 256'(pattern[k]));
        end
    endtask

    initial begin
        req_t r;
        int   total;
        clear_inputs();
        m_ptr = 0; m_rem = 0; m_owner = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dev_a_valid", 256'(bus.dev_a_valid_o), 256'(0));
        chk("rst_host_a_ready", 256'(bus.host_a_ready_o), 256'(0));
        chk("rst_host_d_valid", 256'(bus.host_d_valid_o), 256'(0));
        chk("rst_dev_d_ready", 256'(bus.dev_d_ready_o), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single request from host 1, then its response
        r = mk_req(3'd4, 3'd4, 2'd2, 38'h80000000, '0);
        bus.host_a_valid_i = 2'b10;
        bus.host_a_i[1]    = host_a(r);
        bus.dev_a_ready_i  = 1'b1;
        @(negedge clk);
        chk("single_src", 256'(bus.dev_a_o[ASRC +: SW]), 256'(3'b110));
        chk("single_ready", 256'(bus.host_a_ready_o), 256'(2'b10));
        chk("single_bundle", 256'(bus.dev_a_o), 256'(dev_a(r, 1)));
        model_hs(1, r);
        @(posedge clk); #1;
        bus.host_a_valid_i = '0;
        bus.dev_d_valid_i  = 1'b1;
        bus.dev_d_i        = dev_d(3'd1, 3'd4, 3'd6, 128'hCAFE_0001);
        bus.host_d_ready_i = 2'b11;
        @(negedge clk);
        chk("single_d_valid", 256'(bus.host_d_valid_o), 256'(2'b10));
        chk("single_d_bundle", 256'(bus.host_d_o), 256'(host_d(3'd1, 3'd4, 2'd2, 128'hCAFE_0001)));
        chk("single_d_ready", 256'(bus.dev_d_ready_o), 256'(1));
        @(posedge clk); #1;
        clear_inputs();

        // fairness: both hosts keep single-beat Gets pending
        for (int k = 0; k < 4; k++) begin
            push_req(0, mk_req(3'd4, 3'd4, 2'd0, AW'($urandom), '0));
            push_req(1, mk_req(3'd4, 3'd3, 2'd1, AW'($urandom), '0));
        end
        run(100, 0, 1000);
        chk_order("fair", 8, 16'hAA);

        // burst lock, device always ready then ready every other cycle
        for (int mode = 0; mode < 2; mode++) begin
            push_req(0, mk_req(3'd0, 3'd6, 2'd3, 38'h1000, 128'h100));
            push_req(1, mk_req(3'd4, 3'd2, 2'd0, 38'h2000, '0));
            run(100, mode, 1000);
            chk_order(mode == 0 ? "burst" : "burst_toggle", 5, 16'h10);
        end
        clear_inputs();

        // D backpressure for host 0
        bus.dev_d_valid_i  = 1'b1;
        bus.dev_d_i        = dev_d(3'd1, 3'd4, 3'd1, 128'hBEEF);
        bus.host_d_ready_i = 2'b10;
        repeat (5) begin
            @(negedge clk);
            chk("bp_dev_d_ready", 256'(bus.dev_d_ready_o), 256'(0));
            chk("bp_host_d_valid", 256'(bus.host_d_valid_o), 256'(2'b01));
            chk("bp_host_d_data", 256'(bus.host_d_o), 256'(host_d(3'd1, 3'd4, 2'd1, 128'hBEEF)));
            @(posedge clk); #1;
        end
        bus.host_d_ready_i = 2'b11;
        @(negedge clk);
        chk("bp_release_ready", 256'(bus.dev_d_ready_o), 256'(1));
        chk("bp_release_valid", 256'(bus.host_d_valid_o), 256'(2'b01));
        @(posedge clk); #1;
        clear_inputs();

        // reset in the middle of a 4-beat Put, with the pointer moved off 0 beforehand
        push_req(0, mk_req(3'd4, 3'd0, 2'd0, 38'h40, '0));
        run(100, 0, 1000);
        push_req(0, mk_req(3'd0, 3'd6, 2'd1, 38'h3000, 128'h300));
        run(100, 0, 2);
        rst_n = 1'b0;
        hq[0].delete();
        hq[1].delete();
        clear_inputs();
        m_ptr = 0; m_rem = 0;
        @(negedge clk);
        chk("rst_mid_valid", 256'(bus.dev_a_valid_o), 256'(0));
        chk("rst_mid_ready", 256'(bus.host_a_ready_o), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_req(0, mk_req(3'd4, 3'd4, 2'd0, 38'h50, '0));
        push_req(1, mk_req(3'd4, 3'd4, 2'd0, 38'h60, '0));
        run(100, 0, 1000);
        chk_order("after_reset", 2, 16'h2);

        // A handshake and D beat to host 1 in the same cycle
        r = mk_req(3'd4, 3'd5, 2'd3, 38'h7000, '0);
        bus.host_a_valid_i = 2'b10;
        bus.host_a_i[1]    = host_a(r);
        bus.dev_a_ready_i  = 1'b1;
        bus.dev_d_valid_i  = 1'b1;
        bus.dev_d_i        = dev_d(3'd1, 3'd5, 3'd7, 128'h77);
        bus.host_d_ready_i = 2'b10;
        @(negedge clk);
        chk("conc_a_ready", 256'(bus.host_a_ready_o), 256'(2'b10));
        chk("conc_a_bundle", 256'(bus.dev_a_o), 256'(dev_a(r, 1)));
        chk("conc_d_valid", 256'(bus.host_d_valid_o), 256'(2'b10));
        chk("conc_d_ready", 256'(bus.dev_d_ready_o), 256'(1));
        chk("conc_d_bundle", 256'(bus.host_d_o), 256'(host_d(3'd1, 3'd5, 2'd3, 128'h77)));
        model_hs(1, r);
        @(posedge clk); #1;
        clear_inputs();

        // randomized traffic on both channels
        total = 0;
        for (int k = 0; k < 120; k++) begin
            logic [2:0] op;
            case ($urandom_range(0, 2))
                0:       op = 3'd0;
                1:       op = 3'd1;
                default: op = 3'd4;
            endcase
            r = mk_req(op, 3'($urandom_range(0, 6)), HSW'($urandom), AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
            push_req(int'($urandom_range(0, 1)), r);
            total += nbeats(r);
        end
        run(8000, 2, 100000);
        chk("random_beats", 256'(glog.size()), 256'(total));
        clear_inputs();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
